rotor_param: RTL

Parametrised rotor stage for the Enigma-style cipher datapath. Holds one permutation table of 2^SYM_W symbols, loaded serially at start-up, and answers forward (table lookup) and backward (inverse lookup) queries. Instead of physically shifting the table, it tracks a rotation offset register and keeps a parallel inverse table, so it supports both rotation directions. Outputs are registered with a valid flag, so rotor stages can be pipelined at top level.

---
 rtl/rotor_param.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rotor_param.sv
// rotor_param: one rotor stage of the Enigma-style cipher datapath.
//
// Holds a permutation table of DEPTH = 2**SYM_W symbols, loaded serially one
// entry per cycle after reset. The stage also answers forward lookups
// (logical_table[fwd_in]) and backward lookups (the index j with
// logical_table[j] == bwd_in). Rotation is never done by moving table
// contents. A rotation offset register is kept instead, and a parallel
// inverse table is filled during load. The inverse table lets backward
// queries run in a single cycle.
//
// Ports:
//   clk        - clock
//   srst_n     - synchronous active-low reset
//   load       - load strobe, one entry per cycle when table_idx == TABLE_ID
//   table_idx  - load target selector
//   code_in    - table entry written by an accepted load
//   load_done  - sticky flag, high once all DEPTH entries are written
//   in_valid   - query/rotate request
//   mode       - 0 = rotate right (off += shift), 1 = rotate left (off -= shift)
//   fwd_in     - forward lookup index
//   bwd_in     - backward lookup value
//   shift_amt  - rotation applied after this request
//   out_valid  - fwd_out/bwd_out valid this cycle (1-cycle latency)
//   fwd_out    - logical_table[fwd_in]
//   bwd_out    - logical inverse of bwd_in
module rotor_param #(
  parameter int SYM_W    = 6,
  parameter int SHIFT_W  = 2,
  parameter int IDX_W    = 2,
  parameter int TABLE_ID = 0
) (
  input  logic               clk,
  input  logic               srst_n,
  input  logic               load,
  input  logic [IDX_W-1:0]   table_idx,
  input  logic [SYM_W-1:0]   code_in,
  output logic               load_done,
  input  logic               in_valid,
  input  logic               mode,
  input  logic [SYM_W-1:0]   fwd_in,
  input  logic [SYM_W-1:0]   bwd_in,
  input  logic [SHIFT_W-1:0] shift_amt,
  output logic               out_valid,
  output logic [SYM_W-1:0]   fwd_out,
  output logic [SYM_W-1:0]   bwd_out
);

  localparam int DEPTH = 2 ** SYM_W;
  localparam logic [SYM_W:0]   LAST_IDX = (SYM_W + 1)'(DEPTH - 1);
  localparam logic [IDX_W-1:0] MY_ID    = IDX_W'(TABLE_ID);

  // Physical tables. They have no reset because they are only read once
  // load_done is set.
  logic [SYM_W-1:0] tbl_mem [DEPTH];
  logic [SYM_W-1:0] inv_mem [DEPTH];

  logic [SYM_W:0]   load_cnt_q, load_cnt_d;
  logic [SYM_W-1:0] off_q, off_d;
  logic             load_done_q, load_done_d;
  logic             out_valid_q;
  logic [SYM_W-1:0] fwd_out_q, bwd_out_q;

  logic             load_acc;
  logic             query_acc;
  logic [SYM_W-1:0] wr_idx;
  logic [SYM_W-1:0] shift_ext;
  logic [SYM_W-1:0] fwd_addr;

  always_comb begin
    load_acc    = load && (table_idx == MY_ID) && !load_done_q;
    // A load accepted in the same cycle wins, and the query is dropped.
    query_acc   = in_valid && load_done_q && !load_acc;
    wr_idx      = load_cnt_q[SYM_W-1:0];
    shift_ext   = SYM_W'(shift_amt);
    // Map the logical index back to a physical slot. Wrap is natural modulo DEPTH.
    fwd_addr    = fwd_in - off_q;

    load_cnt_d  = load_cnt_q;
    load_done_d = load_done_q;
    off_d       = off_q;

    if (load_acc) begin
      load_cnt_d = load_cnt_q + 1'b1;
      if (load_cnt_q == LAST_IDX) begin
        load_done_d = 1'b1;
      end
    end

    // The rotation applies after this request. The lookups below still use off_q.
    if (query_acc) begin
      if (mode) begin
        off_d = off_q - shift_ext;
      end else begin
        off_d = off_q + shift_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      load_cnt_q  <= '0;
      load_done_q <= 1'b0;
      off_q       <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      load_done_q <= load_done_d;
      off_q       <= off_d;
    end
  end

  // Table writes. The inverse table records where each code was stored.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      tbl_mem[wr_idx]  <= code_in;
      inv_mem[code_in] <= wr_idx;
    end
  end

  // Registered lookups. The outputs are forced to zero whenever no query
  // is accepted.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      out_valid_q <= 1'b0;
      fwd_out_q   <= '0;
      bwd_out_q   <= '0;
    end else begin
      out_valid_q <= query_acc;
      if (query_acc) begin
        fwd_out_q <= tbl_mem[fwd_addr];
        bwd_out_q <= inv_mem[bwd_in] + off_q;
      end else begin
        fwd_out_q <= '0;
        bwd_out_q <= '0;
      end
    end
  end

  assign load_done = load_done_q;
  assign out_valid = out_valid_q;
  assign fwd_out   = fwd_out_q;
  assign bwd_out   = bwd_out_q;

endmodule
